fpu_arbiter: RTL and testbench

Sequential front end that shares the single combinational half-precision `fpu` between two requesters: requester 0 is the pipeline execute stage and requester 1 is the crypto core. It arbitrates round-robin, registers operands, and drives the FPU with stable inputs for a configurable number of settle cycles. It then captures result and overflow and returns them on one response channel tagged with the requester ID. It also keeps completed-operation and overflow statistics.

---
 rtl/fpu_arbiter.sv | 147 ++++++++++++++
 tb/tb_fpu_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin front end sharing one half-precision FPU
// between the execute stage (id 0) and the crypto core (id 1).
module fpu_arbiter #(
    parameter int unsigned FPU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_vld,
    output logic [1:0]  req_rdy,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic [1:0]  req_op,
    output logic        fpu_vld,
    output logic [15:0] fpu_a,
    output logic [15:0] fpu_b,
    output logic [3:0]  fpu_opcode,
    input  logic [15:0] fpu_res,
    input  logic        fpu_ovf,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic        rsp_id,
    output logic [15:0] rsp_res,
    output logic        rsp_ovf,
    output logic [15:0] ops_done,
    output logic [7:0]  ovf_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(FPU_LAT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_ptr;
    logic [3:0]  r_cnt;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_op;
    logic        r_id;
    logic [15:0] r_res;
    logic        r_ovf;
    logic [15:0] r_ops;
    logic [7:0]  r_ovfc;

    logic        w_gid;
    logic        w_grant;
    logic        w_sample;
    logic        w_hs;

    // pointer only matters when both requesters compete
    assign w_gid    = (req_vld == 2'b11) ? r_ptr : req_vld[1];
    assign w_grant  = (r_state == S_IDLE) && (|req_vld) && !rst;
    assign w_sample = (r_state == S_ISSUE) && (r_cnt == 4'd0);
    assign w_hs     = (r_state == S_RESP) && rsp_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_grant) w_next = S_ISSUE;
            S_ISSUE: if (w_sample) w_next = S_RESP;
            S_RESP:  if (w_hs) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_rdy    = 2'b00;
        fpu_vld    = 1'b0;
        fpu_opcode = 4'b0000;
        rsp_vld    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_grant) req_rdy = w_gid ? 2'b10 : 2'b01;
            end
            S_ISSUE: begin
                fpu_vld    = 1'b1;
                fpu_opcode = r_op ? 4'b1111 : 4'b1110;
            end
            S_RESP: begin
                rsp_vld = 1'b1;
            end
            default: begin
                rsp_vld = 1'b0;
            end
        endcase
    end

    // operand registers drive the FPU directly so idle cycles never toggle them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= 1'b0;
            r_cnt  <= 4'd0;
            r_a    <= 16'd0;
            r_b    <= 16'd0;
            r_op   <= 1'b0;
            r_id   <= 1'b0;
            r_res  <= 16'd0;
            r_ovf  <= 1'b0;
            r_ops  <= 16'd0;
            r_ovfc <= 8'd0;
        end else begin
            if (w_grant) begin
                r_a   <= w_gid ? req1_a : req0_a;
                r_b   <= w_gid ? req1_b : req0_b;
                r_op  <= req_op[w_gid];
                r_id  <= w_gid;
                r_cnt <= LAT_M1;
            end else if ((r_state == S_ISSUE) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_sample) begin
                r_res <= fpu_res;
                r_ovf <= fpu_ovf;
            end
            if (w_hs) begin
                r_ops <= r_ops + 16'd1;
                if (r_ovf && (r_ovfc != 8'hFF)) begin
                    r_ovfc <= r_ovfc + 8'd1;
                end
                r_ptr <= ~r_id;
            end
        end
    end

    assign fpu_a    = r_a;
    assign fpu_b    = r_b;
    assign rsp_id   = r_id;
    assign rsp_res  = r_res;
    assign rsp_ovf  = r_ovf;
    assign ops_done = r_ops;
    assign ovf_cnt  = r_ovfc;

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed vectors for fpu_arbiter against a small
// lookup-table FPU that only answers after its inputs have settled.
module tb_fpu_arbiter;

    localparam int LAT = 3;

    logic        clk;
    logic        rst;
    logic [1:0]  req_vld;
    logic [1:0]  req_rdy;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic [1:0]  req_op;
    logic        fpu_vld;
    logic [15:0] fpu_a;
    logic [15:0] fpu_b;
    logic [3:0]  fpu_opcode;
    logic [15:0] fpu_res;
    logic        fpu_ovf;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic        rsp_id;
    logic [15:0] rsp_res;
    logic        rsp_ovf;
    logic [15:0] ops_done;
    logic [7:0]  ovf_cnt;

    int n_chk;
    int n_fail;
    int exp_ops;
    int exp_ovf;
    logic exp_ptr;

    fpu_arbiter #(.FPU_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_a(req1_a), .req1_b(req1_b),
        .req_op(req_op),
        .fpu_vld(fpu_vld), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_opcode(fpu_opcode),
        .fpu_res(fpu_res), .fpu_ovf(fpu_ovf),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_ovf(rsp_ovf),
        .ops_done(ops_done), .ovf_cnt(ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] model(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [3:0] opc);
        logic [16:0] r;
        r = {1'b0, 16'hBAD0};
        if (opc == 4'b1110) begin
            if (a == 16'h3C00 && b == 16'h4000) r = {1'b0, 16'h4200};
            if (a == 16'h4000 && b == 16'h4000) r = {1'b0, 16'h4400};
            if (a == 16'h3800 && b == 16'h3800) r = {1'b0, 16'h3C00};
            if (a == 16'h4400 && b == 16'h4000) r = {1'b0, 16'h4600};
        end else if (opc == 4'b1111) begin
            if (a == 16'h4000 && b == 16'h4200) r = {1'b0, 16'h4600};
            if (a == 16'h7BFF && b == 16'h7BFF) r = {1'b1, 16'h7C00};
            if (a == 16'h3C00 && b == 16'hC000) r = {1'b0, 16'hC000};
            if (a == 16'h4400 && b == 16'h4000) r = {1'b0, 16'h4800};
        end
        return r;
    endfunction

    int settle;
    logic [16:0] w_m;

    always_ff @(posedge clk) begin
        if (!fpu_vld) settle <= 0;
        else if (settle < 15) settle <= settle + 1;
    end

    // garbage until the inputs have been held for LAT cycles
    always_comb begin
        w_m = model(fpu_a, fpu_b, fpu_opcode);
        fpu_res = 16'hDEAD;
        fpu_ovf = 1'b0;
        if (fpu_vld && settle >= LAT - 1) begin
            fpu_res = w_m[15:0];
            fpu_ovf = w_m[16];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_rdy"}, 32'(req_rdy), 0);
        chk({tag, "_fpu_vld"}, 32'(fpu_vld), 0);
        chk({tag, "_fpu_a"}, 32'(fpu_a), 0);
        chk({tag, "_fpu_b"}, 32'(fpu_b), 0);
        chk({tag, "_fpu_opc"}, 32'(fpu_opcode), 0);
        chk({tag, "_rsp_vld"}, 32'(rsp_vld), 0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
        chk({tag, "_rsp_res"}, 32'(rsp_res), 0);
        chk({tag, "_rsp_ovf"}, 32'(rsp_ovf), 0);
        chk({tag, "_ops_done"}, 32'(ops_done), 0);
        chk({tag, "_ovf_cnt"}, 32'(ovf_cnt), 0);
    endtask

    task automatic note_rsp(input logic id, input logic ovf);
        exp_ops = (exp_ops + 1) & 16'hFFFF;
        if (ovf && exp_ovf != 255) exp_ovf++;
        exp_ptr = ~id;
    endtask

    task automatic run_one(input logic id, input logic op,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] er, input logic eo);
        int w;
        @(negedge clk);
        if (id) begin
            req1_a = a; req1_b = b; req0_a = 16'h1111; req0_b = 16'h1111;
            req_op = {op, ~op};
            req_vld = 2'b10;
        end else begin
            req0_a = a; req0_b = b; req1_a = 16'h1111; req1_b = 16'h1111;
            req_op = {~op, op};
            req_vld = 2'b01;
        end
        rsp_rdy = 1'b1;
        #1;
        w = 0;
        while (req_rdy == 2'b00 && w < 8) begin
            @(negedge clk); #1; w++;
        end
        chk("grant", 32'(req_rdy), id ? 2 : 1);
        @(negedge clk); req_vld = 2'b00; #1;
        for (int k = 0; k < LAT; k++) begin
            chk("fpu_vld", 32'(fpu_vld), 1);
            chk("fpu_opcode", 32'(fpu_opcode), op ? 4'hF : 4'hE);
            chk("fpu_a", 32'(fpu_a), 32'(a));
            chk("fpu_b", 32'(fpu_b), 32'(b));
            chk("early_rsp", 32'(rsp_vld), 0);
            @(negedge clk); #1;
        end
        chk("rsp_vld", 32'(rsp_vld), 1);
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_res", 32'(rsp_res), 32'(er));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(eo));
        chk("idle_fpu_vld", 32'(fpu_vld), 0);
        chk("idle_fpu_opc", 32'(fpu_opcode), 0);
        chk("hold_fpu_a", 32'(fpu_a), 32'(a));
        note_rsp(id, eo);
        @(negedge clk); #1;
        chk("rsp_gone", 32'(rsp_vld), 0);
        chk("ops_done", 32'(ops_done), 32'(exp_ops));
        chk("ovf_cnt", 32'(ovf_cnt), 32'(exp_ovf));
    endtask

    task automatic drain(input logic id, input logic [15:0] er,
                         input logic eo);
        int w;
        @(negedge clk); req_vld = 2'b00; #1;
        w = 0;
        while (rsp_vld !== 1'b1 && w < LAT + 4) begin
            @(negedge clk); #1; w++;
        end
        chk("drain_vld", 32'(rsp_vld), 1);
        chk("drain_id", 32'(rsp_id), 32'(id));
        chk("drain_res", 32'(rsp_res), 32'(er));
        chk("drain_ovf", 32'(rsp_ovf), 32'(eo));
        note_rsp(id, eo);
        @(negedge clk); #1;
        chk("drain_gone", 32'(rsp_vld), 0);
        chk("drain_ops", 32'(ops_done), 32'(exp_ops));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_vld = 2'b11; #1;
        chk_zero("rst");
        @(negedge clk);
        rst = 1'b0; req_vld = 2'b00;
        exp_ops = 0; exp_ovf = 0; exp_ptr = 1'b0;
    endtask

    typedef struct {
        logic        id;
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        ovf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic q[$];
        logic ep;
        logic gid;
        int grants;
        int last;
        int cyc;

        n_chk = 0; n_fail = 0;
        exp_ops = 0; exp_ovf = 0; exp_ptr = 1'b0;
        rst = 1'b1; req_vld = 2'b11; rsp_rdy = 1'b0; req_op = 2'b00;
        req0_a = 16'h0; req0_b = 16'h0; req1_a = 16'h0; req1_b = 16'h0;

        vecs[0] = '{1'b0, 1'b0, 16'h3C00, 16'h4000, 16'h4200, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 16'h4000, 16'h4200, 16'h4600, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 16'h4000, 16'h4000, 16'h4400, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 16'h3C00, 16'hC000, 16'hC000, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 16'h3800, 16'h3800, 16'h3C00, 1'b0};

        @(negedge clk); #1;
        chk_zero("por");
        do_reset();

        for (int i = 0; i < 6; i++) begin
            run_one(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].res, vecs[i].ovf);
        end

        // contention: both requesters held valid
        @(negedge clk);
        req0_a = 16'h4400; req0_b = 16'h4000;
        req1_a = 16'h4400; req1_b = 16'h4000;
        req_op = 2'b10; req_vld = 2'b11; rsp_rdy = 1'b1;
        #1;
        ep = exp_ptr; grants = 0; last = 0; cyc = 0;
        while ((grants < 4 || q.size() > 0) && cyc < 4 * (LAT + 2) + 8) begin
            if (req_rdy != 2'b00) begin
                chk("rr_grant", 32'(req_rdy), ep ? 2 : 1);
                if (grants > 0) chk("rr_interval", 32'(cyc - last), LAT + 2);
                q.push_back(ep);
                ep = ~ep;
                last = cyc;
                grants++;
            end
            if (rsp_vld) begin
                if (q.size() > 0) begin
                    gid = q.pop_front();
                    chk("rr_rsp_id", 32'(rsp_id), 32'(gid));
                    chk("rr_rsp_res", 32'(rsp_res), gid ? 16'h4800 : 16'h4600);
                    note_rsp(gid, 1'b0);
                end else begin
                    chk("rr_extra_rsp", 32'(rsp_vld), 0);
                end
            end
            @(negedge clk);
            if (grants >= 4) req_vld = 2'b00;
            #1;
            cyc++;
        end
        chk("rr_grants", 32'(grants), 4);
        chk("rr_pending", 32'(q.size()), 0);
        chk("rr_ops", 32'(ops_done), 32'(exp_ops));

        // backpressure with both requesters waiting
        @(negedge clk);
        req_vld = 2'b01; rsp_rdy = 1'b0; #1;
        chk("bp_grant", 32'(req_rdy), 1);
        @(negedge clk); req_vld = 2'b00; #1;
        cyc = 0;
        while (rsp_vld !== 1'b1 && cyc < LAT + 4) begin
            @(negedge clk); #1; cyc++;
        end
        chk("bp_rsp_up", 32'(rsp_vld), 1);
        @(negedge clk); req_vld = 2'b11;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("bp_rsp_vld", 32'(rsp_vld), 1);
            chk("bp_rsp_res", 32'(rsp_res), 16'h4600);
            chk("bp_rsp_id", 32'(rsp_id), 0);
            chk("bp_req_rdy", 32'(req_rdy), 0);
            chk("bp_fpu_vld", 32'(fpu_vld), 0);
            chk("bp_fpu_a", 32'(fpu_a), 16'h4400);
            chk("bp_ops", 32'(ops_done), 32'(exp_ops));
            @(negedge clk);
        end
        rsp_rdy = 1'b1; #1;
        chk("hs_req_rdy", 32'(req_rdy), 0);
        chk("hs_rsp_vld", 32'(rsp_vld), 1);
        note_rsp(1'b0, 1'b0);
        @(negedge clk); #1;
        chk("hs_once", 32'(rsp_vld), 0);
        chk("hs_ops", 32'(ops_done), 32'(exp_ops));
        chk("post_hs_grant", 32'(req_rdy), 2);
        drain(1'b1, 16'h4800, 1'b0);

        // overflow statistics from a clean reset
        do_reset();
        for (int i = 0; i < 256; i++) begin
            run_one(1'b1, 1'b1, 16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1);
        end
        chk("sat_ovf_cnt", 32'(ovf_cnt), 255);
        chk("sat_ops_done", 32'(ops_done), 256);

        // reset in the middle of an issue
        run_one(1'b0, 1'b0, 16'h3C00, 16'h4000, 16'h4200, 1'b0);
        @(negedge clk);
        req1_a = 16'h4000; req1_b = 16'h4200; req_op = 2'b10;
        req_vld = 2'b10; #1;
        chk("mid_grant", 32'(req_rdy), 2);
        @(negedge clk); req_vld = 2'b00; #1;
        chk("mid_issue", 32'(fpu_vld), 1);
        rst = 1'b1; #1;
        chk_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        exp_ops = 0; exp_ovf = 0; exp_ptr = 1'b0;
        #1;
        for (int k = 0; k < LAT + 4; k++) begin
            chk("mid_no_rsp", 32'(rsp_vld), 0);
            @(negedge clk); #1;
        end
        @(negedge clk);
        req0_a = 16'h3C00; req0_b = 16'h4000;
        req1_a = 16'h4000; req1_b = 16'h4200;
        req_op = 2'b10; req_vld = 2'b11; #1;
        chk("mid_ptr0", 32'(req_rdy), 1);
        drain(1'b0, 16'h4200, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
